intc_ctrl: RTL

- Programmable interrupt controller between the peripheral interrupt lines (Timer, ButtonSwitch, spare sources) and the CPU HWInt port.
- Latches and masks requests, and selects one source by priority.
- Holds the one-hot selected request on the CPU interrupt lines until software writes end-of-interrupt (EOI).
- Sits in the SouthBridge address space as a register-mapped peripheral with the same Addr/WE/Din/Dout style as the other devices.

---
 rtl/intc_pkg.sv | 18 +
 rtl/intc_prio_enc.sv | 39 +++
 rtl/intc_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/intc_pkg.sv
// Shared definitions for the intc_ctrl interrupt controller: register offsets,
// FSM state encoding and field positions.
package intc_pkg;

    localparam logic [1:0] REG_MASK = 2'd0;
    localparam logic [1:0] REG_PEND = 2'd1;
    localparam logic [1:0] REG_MODE = 2'd2;
    localparam logic [1:0] REG_ID   = 2'd3;

    localparam int ID_W_DEF  = 3;
    localparam int VALID_BIT = 31;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_SERVICE = 1'b1
    } state_e;

endpackage

// File: rtl/intc_prio_enc.sv
// Rotating-start priority encoder: returns the first set request found when
// scanning upward from start_i, wrapping modulo N_SRC.
module intc_prio_enc #(
    parameter int N_SRC = 6,
    parameter int ID_W  = 3
) (
    input  logic [N_SRC-1:0] req_i,
    input  logic [ID_W-1:0]  start_i,
    output logic [ID_W-1:0]  id_o,
    output logic             any_o
);

    // Pick the request with the smallest wrapped distance from start_i.
    always_comb begin
        int start_v;
        int dist_v;
        int best_v;
        start_v = int'(start_i);
        best_v  = N_SRC;
        dist_v  = 0;
        id_o    = '0;
        any_o   = 1'b0;
        for (int j = 0; j < N_SRC; j++) begin
            if (j >= start_v) begin
                dist_v = j - start_v;
            end else begin
                dist_v = j + N_SRC - start_v;
            end
            if (req_i[j] && (dist_v < best_v)) begin
                best_v = dist_v;
                id_o   = ID_W'(j);
                any_o  = 1'b1;
            end else begin
                best_v = best_v;
            end
        end
    end

endmodule

// File: rtl/intc_ctrl.sv
// Register-mapped interrupt controller: latches and masks requests, then holds one
// selected source on hw_int until EOI. Define INTC_ROUND_ROBIN_EN for rotating priority.
module intc_ctrl
    import intc_pkg::*;
#(
    parameter int N_SRC = 6,
    parameter int ID_W  = ID_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [29:0]      Addr,
    input  logic             WE,
    input  logic [31:0]      Din,
    output logic [31:0]      Dout,
    input  logic [N_SRC-1:0] irq_in,
    output logic [N_SRC-1:0] hw_int,
    output logic             busy
);

    logic [N_SRC-1:0] mask_q, mask_d;
    logic [N_SRC-1:0] mode_q, mode_d;
    logic [N_SRC-1:0] pend_q, pend_d;
    logic [N_SRC-1:0] irq_prev_q;
    logic [N_SRC-1:0] hw_int_q, hw_int_d;
    logic [ID_W-1:0]  sel_q, sel_d;
    state_e           state_q, state_d;

    logic [1:0]       reg_sel_s;
    logic [N_SRC-1:0] eligible_s;
    logic [N_SRC-1:0] clr_s;
    logic             eoi_s;
    logic             sel_elig_s;
    logic [ID_W-1:0]  start_s;
    logic [ID_W-1:0]  enc_id_s;
    logic             enc_any_s;
    logic             unused_s;

    function automatic logic [N_SRC-1:0] onehot(input logic [ID_W-1:0] idx);
        logic [N_SRC-1:0] v;
        v = '0;
        for (int i = 0; i < N_SRC; i++) begin
            v[i] = (idx == ID_W'(i));
        end
        return v;
    endfunction

    assign reg_sel_s  = Addr[1:0];
    assign unused_s   = ^{Addr[29:2], Din[31:N_SRC]};
    assign eligible_s = pend_q & mask_q;
    assign eoi_s      = WE && (reg_sel_s == REG_ID) && (state_q == ST_SERVICE);
    assign sel_elig_s = |(eligible_s & onehot(sel_q));
    assign clr_s      = ((WE && (reg_sel_s == REG_PEND)) ? Din[N_SRC-1:0] : {N_SRC{1'b0}})
                      | (eoi_s ? onehot(sel_q) : {N_SRC{1'b0}});

    intc_prio_enc #(
        .N_SRC (N_SRC),
        .ID_W  (ID_W)
    ) u_prio_enc (
        .req_i   (eligible_s),
        .start_i (start_s),
        .id_o    (enc_id_s),
        .any_o   (enc_any_s)
    );

`ifdef INTC_ROUND_ROBIN_EN
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

    // Pointer advances past an acknowledged source; cancelled services leave it alone.
    always_comb begin
        if (eoi_s) begin
            if (sel_q == ID_W'(N_SRC - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = sel_q + ID_W'(1);
            end
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign start_s = rr_ptr_q;
`else
    assign start_s = '0;
`endif

    // Register writes and pending latch; on an edge bit a new edge beats any clear.
    always_comb begin
        if (WE && (reg_sel_s == REG_MASK)) begin
            mask_d = Din[N_SRC-1:0];
        end else begin
            mask_d = mask_q;
        end
        if (WE && (reg_sel_s == REG_MODE)) begin
            mode_d = Din[N_SRC-1:0];
        end else begin
            mode_d = mode_q;
        end
        pend_d = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (mode_q[i]) begin
                pend_d[i] = (irq_in[i] & ~irq_prev_q[i]) | (pend_q[i] & ~clr_s[i]);
            end else begin
                pend_d[i] = irq_in[i];
            end
        end
    end

    // Register file state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q     <= '0;
            mode_q     <= '0;
            pend_q     <= '0;
            irq_prev_q <= '0;
        end else begin
            mask_q     <= mask_d;
            mode_q     <= mode_d;
            pend_q     <= pend_d;
            irq_prev_q <= irq_in;
        end
    end

    // FSM next state: selection is frozen for the whole service.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        case (state_q)
            ST_IDLE: begin
                if (enc_any_s) begin
                    state_d = ST_SERVICE;
                    sel_d   = enc_id_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (eoi_s || !sel_elig_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SERVICE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // hw_int tracks the state being entered so it lines up with busy.
    always_comb begin
        if (state_d == ST_SERVICE) begin
            hw_int_d = onehot(sel_d);
        end else begin
            hw_int_d = '0;
        end
        Dout = '0;
        case (reg_sel_s)
            REG_MASK: Dout[N_SRC-1:0] = mask_q;
            REG_PEND: Dout[N_SRC-1:0] = pend_q;
            REG_MODE: Dout[N_SRC-1:0] = mode_q;
            REG_ID: begin
                if (state_q == ST_SERVICE) begin
                    Dout[VALID_BIT]  = 1'b1;
                    Dout[ID_W-1:0]   = sel_q;
                end else begin
                    Dout = '0;
                end
            end
            default: Dout = '0;
        endcase
    end

    // FSM state, selection and CPU request registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            sel_q    <= '0;
            hw_int_q <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            hw_int_q <= hw_int_d;
        end
    end

    assign hw_int = hw_int_q;
    assign busy   = (state_q == ST_SERVICE);

endmodule
